// File: rtl/display_src_sel_if.sv
// Bus bundle between the display source selector and whatever drives it.
// The slave side is the selector; the master side supplies sources and
// control requests and receives the decoder value and status.
interface display_src_sel_if #(
  parameter int WIDTH = 12,
  parameter int NCH   = 3
);
  localparam int SEL_W = $clog2(NCH + 1);

  logic [NCH*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]     sel_in;
  logic                 sel_load;
  logic                 next;
  logic                 auto_en;
  logic                 freeze;
  logic                 blink_en;
  logic [WIDTH-1:0]     time_to_decode;
  logic [SEL_W-1:0]     cur_sel;
  logic                 blank;
  logic                 sel_chg;

  modport master (
    output src_data, sel_in, sel_load, next, auto_en, freeze, blink_en,
    input  time_to_decode, cur_sel, blank, sel_chg
  );

  modport slave (
    input  src_data, sel_in, sel_load, next, auto_en, freeze, blink_en,
    output time_to_decode, cur_sel, blank, sel_chg
  );
endinterface

// File: rtl/display_src_sel.sv
// Display source selector: picks one of NCH packed mm:ss values for the
// display decoder. Selection is set directly, stepped by a pulse, or
// cycled automatically; the output can be frozen and blinked.
// Code 0 means "blank"; codes 1..NCH are channels.
module display_src_sel #(
  parameter int WIDTH        = 12,
  parameter int NCH          = 3,
  parameter int BLINK_PERIOD = 10,
  parameter int AUTO_PERIOD  = 100
) (
  input logic              clk,
  input logic              nrst,
  display_src_sel_if.slave bus
);

  localparam int SEL_W   = $clog2(NCH + 1);
  localparam int AUTO_W  = $clog2(AUTO_PERIOD);
  localparam int BLINK_W = $clog2(BLINK_PERIOD);

  localparam logic [AUTO_W-1:0]  AUTO_LAST  = AUTO_W'(AUTO_PERIOD - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

  // Out-of-range load codes fall back to blank.
  function automatic logic [SEL_W-1:0] f_clamp(input logic [SEL_W-1:0] s);
    return (int'(s) <= NCH) ? s : '0;
  endfunction

  // Step to the next channel; blank steps to channel 1 and the last
  // channel wraps to 1, so stepping never lands on blank.
  function automatic logic [SEL_W-1:0] f_advance(input logic [SEL_W-1:0] s);
    return (int'(s) >= NCH) ? SEL_W'(1) : s + SEL_W'(1);
  endfunction

  logic [SEL_W-1:0]   r_sel_p0;
  logic [SEL_W-1:0]   r_sel_p1;
  logic               r_chg_p1;
  logic [WIDTH-1:0]   r_ttd_p1;
  logic [AUTO_W-1:0]  r_auto_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;

  logic [SEL_W-1:0]   w_sel_nxt;
  logic [WIDTH-1:0]   w_slice;
  logic               w_auto_tick;
  logic               w_auto_clr;

  assign w_auto_tick = bus.auto_en && (r_auto_cnt == AUTO_LAST);
  assign w_auto_clr  = !bus.auto_en || bus.sel_load || bus.next;

  // Next selection: explicit load beats a step pulse, which beats auto tick.
  always_comb begin
    w_sel_nxt = r_sel_p0;
    if (bus.sel_load) begin
      w_sel_nxt = f_clamp(bus.sel_in);
    end else if (bus.next || w_auto_tick) begin
      w_sel_nxt = f_advance(r_sel_p0);
    end
  end

  // Channel slice addressed by the registered selection; blank gives zero.
  always_comb begin
    w_slice = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (int'(r_sel_p0) == k) begin
        w_slice = bus.src_data[(k-1)*WIDTH +: WIDTH];
      end
    end
  end

  // Auto-cycle timer; any manual selection activity restarts the interval.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_auto_cnt <= '0;
    end else if (w_auto_clr || w_auto_tick) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
    end
  end

  // ---- stage p0: selection register ----
  // Selection register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sel_p0 <= '0;
    end else begin
      r_sel_p0 <= w_sel_nxt;
    end
  end

  // ---- stage p1: decoder value and change flag, one edge behind p0 ----
  // Change detect against the previous selection, so the pulse lines up
  // with the first edge that loads the new channel value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sel_p1 <= '0;
      r_chg_p1 <= 1'b0;
    end else begin
      r_sel_p1 <= r_sel_p0;
      r_chg_p1 <= (r_sel_p0 != r_sel_p1);
    end
  end

  // Decoder value; freeze holds it while selection logic keeps running.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ttd_p1 <= '0;
    end else if (!bus.freeze) begin
      r_ttd_p1 <= w_slice;
    end
  end

  // Blink half-period timer and phase; disabling blink restarts both.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (!bus.blink_en) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign bus.cur_sel        = r_sel_p0;
  assign bus.time_to_decode = r_ttd_p1;
  assign bus.sel_chg        = r_chg_p1;
  assign bus.blank          = (r_sel_p0 == '0) | (bus.blink_en & r_phase);

endmodule

// File: tb/tb_display_src_sel.sv
// Bench for display_src_sel: directed stimulus with literal checkpoints,
// plus a behavioural model compared against the DUT every cycle.
module tb_display_src_sel;

  localparam int WIDTH = 12;
  localparam int NCH   = 3;
  localparam int BP    = 10;
  localparam int AP    = 100;

  logic clk = 1'b0;
  logic nrst;

  always #5 clk = ~clk;

  display_src_sel_if #(.WIDTH(WIDTH), .NCH(NCH)) u_if ();
  display_src_sel_if #(.WIDTH(WIDTH), .NCH(4))   u_if4 ();

  display_src_sel #(.WIDTH(WIDTH), .NCH(NCH), .BLINK_PERIOD(BP), .AUTO_PERIOD(AP)) u_dut (
    .clk (clk),
    .nrst(nrst),
    .bus (u_if.slave)
  );

  display_src_sel #(.WIDTH(WIDTH), .NCH(4), .BLINK_PERIOD(BP), .AUTO_PERIOD(AP)) u_dut4 (
    .clk (clk),
    .nrst(nrst),
    .bus (u_if4.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Model state: selection history, decoder value, and ages in cycles.
  int               m_sel       = 0;
  int               m_prev      = 0;
  logic [WIDTH-1:0] m_ttd       = '0;
  bit               m_chg       = 1'b0;
  int               m_auto_age  = 0;
  int               m_blink_age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_chan(input int s);
    if (s == 0) return '0;
    return u_if.src_data[(s-1)*WIDTH +: WIDTH];
  endfunction

  function automatic bit m_blank();
    return (m_sel == 0) || (u_if.blink_en && (((m_blink_age / BP) % 2) == 1));
  endfunction

  task automatic model_step();
    int nsel;
    bit tick;
    if (!nrst) begin
      m_sel = 0; m_prev = 0; m_ttd = '0; m_chg = 1'b0;
      m_auto_age = 0; m_blink_age = 0;
      return;
    end
    tick = u_if.auto_en && ((m_auto_age % AP) == AP - 1);
    nsel = m_sel;
    if (u_if.sel_load)
      nsel = (int'(u_if.sel_in) <= NCH) ? int'(u_if.sel_in) : 0;
    else if (u_if.next || tick)
      nsel = (m_sel % NCH) + 1;
    m_chg  = (m_sel != m_prev);
    m_prev = m_sel;
    if (!u_if.freeze) m_ttd = m_chan(m_sel);
    m_sel = nsel;
    m_auto_age  = (!u_if.auto_en || u_if.sel_load || u_if.next) ? 0 : m_auto_age + 1;
    m_blink_age = u_if.blink_en ? m_blink_age + 1 : 0;
  endtask

  initial forever begin
    @(posedge clk or negedge nrst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cmp_cur_sel", 32'(u_if.cur_sel), 32'(m_sel));
      chk("cmp_time",    32'(u_if.time_to_decode), 32'(m_ttd));
      chk("cmp_sel_chg", 32'(u_if.sel_chg), 32'(m_chg));
      chk("cmp_blank",   32'(u_if.blank), 32'(m_blank()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    nrst = 1'b0;
    u_if.src_data = {12'h3A7, 12'h135, 12'h010};
    u_if.sel_in = '0; u_if.sel_load = 0; u_if.next = 0;
    u_if.auto_en = 0; u_if.freeze = 0; u_if.blink_en = 0;
    u_if4.src_data = {12'h444, 12'h333, 12'h222, 12'h111};
    u_if4.sel_in = '0; u_if4.sel_load = 0; u_if4.next = 0;
    u_if4.auto_en = 0; u_if4.freeze = 0; u_if4.blink_en = 0;

    cyc(3);
    chk("rst_cur_sel", 32'(u_if.cur_sel), 0);
    chk("rst_time", 32'(u_if.time_to_decode), 0);
    chk("rst_sel_chg", 32'(u_if.sel_chg), 0);
    chk("rst_blank", 32'(u_if.blank), 1);
    cmp_en = 1'b1;
    nrst = 1'b1;
    cyc(1);

    // Load channel 2; value and change pulse arrive one edge later.
    u_if.sel_in = 2; u_if.sel_load = 1; cyc(1); u_if.sel_load = 0;
    chk("load2_cur_sel", 32'(u_if.cur_sel), 2);
    chk("load2_blank", 32'(u_if.blank), 0);
    chk("load2_chg_early", 32'(u_if.sel_chg), 0);
    cyc(1);
    chk("load2_time", 32'(u_if.time_to_decode), 32'h135);
    chk("load2_chg", 32'(u_if.sel_chg), 1);
    cyc(1);
    chk("load2_chg_off", 32'(u_if.sel_chg), 0);

    // Wrap and priority.
    u_if.sel_in = 3; u_if.sel_load = 1; cyc(1); u_if.sel_load = 0;
    chk("load3_cur_sel", 32'(u_if.cur_sel), 3);
    u_if.next = 1; cyc(1); u_if.next = 0;
    chk("next_wrap", 32'(u_if.cur_sel), 1);
    u_if.sel_in = 3; u_if.sel_load = 1; u_if.next = 1; cyc(1);
    u_if.sel_load = 0; u_if.next = 0;
    chk("load_beats_next", 32'(u_if.cur_sel), 3);
    cyc(1);

    // Auto cycling from channel 1.
    u_if.sel_in = 1; u_if.sel_load = 1; cyc(1); u_if.sel_load = 0;
    u_if.auto_en = 1;
    cyc(99);  chk("auto_99", 32'(u_if.cur_sel), 1);
    cyc(1);   chk("auto_100", 32'(u_if.cur_sel), 2);
    cyc(99);  chk("auto_199", 32'(u_if.cur_sel), 2);
    cyc(1);   chk("auto_200", 32'(u_if.cur_sel), 3);
    cyc(100); chk("auto_300", 32'(u_if.cur_sel), 1);
    cyc(50);
    u_if.next = 1; cyc(1); u_if.next = 0;
    chk("auto_next", 32'(u_if.cur_sel), 2);
    cyc(99);  chk("auto_restart_99", 32'(u_if.cur_sel), 2);
    cyc(1);   chk("auto_restart_100", 32'(u_if.cur_sel), 3);
    u_if.auto_en = 0;

    // Freeze holds the decoder value.
    u_if.sel_in = 1; u_if.sel_load = 1; cyc(1); u_if.sel_load = 0;
    cyc(1);
    chk("frz_before", 32'(u_if.time_to_decode), 32'h010);
    u_if.freeze = 1; u_if.src_data[11:0] = 12'h020;
    cyc(3);
    chk("frz_hold", 32'(u_if.time_to_decode), 32'h010);
    chk("frz_sel", 32'(u_if.cur_sel), 1);
    u_if.freeze = 0;
    cyc(1);
    chk("frz_release", 32'(u_if.time_to_decode), 32'h020);

    // Blink: 10 cycles shown, 10 blanked.
    u_if.blink_en = 1;
    for (int i = 1; i <= 35; i++) begin
      cyc(1);
      chk("blink_phase", 32'(u_if.blank), 32'((i / 10) % 2));
    end
    u_if.blink_en = 0;
    cyc(1); chk("blink_off", 32'(u_if.blank), 0);
    u_if.blink_en = 1;
    cyc(1); chk("blink_restart_1", 32'(u_if.blank), 0);
    cyc(8); chk("blink_restart_9", 32'(u_if.blank), 0);
    cyc(1); chk("blink_restart_10", 32'(u_if.blank), 1);
    u_if.blink_en = 0;
    cyc(1);

    // Asynchronous reset in the middle of an auto interval.
    u_if.sel_in = 2; u_if.sel_load = 1; cyc(1); u_if.sel_load = 0;
    u_if.auto_en = 1;
    cyc(37);
    #1 nrst = 1'b0;
    #1;
    chk("arst_cur_sel", 32'(u_if.cur_sel), 0);
    chk("arst_time", 32'(u_if.time_to_decode), 0);
    chk("arst_chg", 32'(u_if.sel_chg), 0);
    chk("arst_blank", 32'(u_if.blank), 1);
    cyc(2);
    nrst = 1'b1;
    cyc(99); chk("arst_auto_99", 32'(u_if.cur_sel), 0);
    cyc(1);  chk("arst_auto_100", 32'(u_if.cur_sel), 1);
    cyc(1);
    chk("arst_auto_time", 32'(u_if.time_to_decode), 32'h020);
    chk("arst_auto_chg", 32'(u_if.sel_chg), 1);
    u_if.auto_en = 0;

    // Four-channel instance: out-of-range load codes select blank.
    u_if4.sel_in = 4; u_if4.sel_load = 1; cyc(1); u_if4.sel_load = 0;
    chk("n4_load4", 32'(u_if4.cur_sel), 4);
    cyc(1);
    chk("n4_time4", 32'(u_if4.time_to_decode), 32'h444);
    u_if4.next = 1; cyc(1); u_if4.next = 0;
    chk("n4_wrap", 32'(u_if4.cur_sel), 1);
    u_if4.sel_in = 7; u_if4.sel_load = 1; cyc(1); u_if4.sel_load = 0;
    chk("n4_load7_sel", 32'(u_if4.cur_sel), 0);
    chk("n4_load7_blank", 32'(u_if4.blank), 1);
    cyc(1);
    chk("n4_load7_time", 32'(u_if4.time_to_decode), 0);
    chk("n4_load7_chg", 32'(u_if4.sel_chg), 1);
    u_if4.sel_in = 3; u_if4.sel_load = 1; cyc(1); u_if4.sel_load = 0;
    chk("n4_load3", 32'(u_if4.cur_sel), 3);
    u_if4.sel_in = 5; u_if4.sel_load = 1; cyc(1); u_if4.sel_load = 0;
    chk("n4_load5", 32'(u_if4.cur_sel), 0);
    cyc(2);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
